// File: rtl/sram_access_arbiter.sv
// Three-way SRAM access arbiter: V fixed-high priority, U/D round-robin,
// registered SRAM command, read-return tracking and a freeze/drain handshake.
module sram_access_arbiter #(
   parameter int READ_LATENCY = 2
) (
   input  logic        Clock,
   input  logic        Resetn,

   input  logic        V_req,
   input  logic        U_req,
   input  logic        D_req,
   input  logic        V_we_n,
   input  logic        U_we_n,
   input  logic        D_we_n,
   input  logic [17:0] V_addr,
   input  logic [17:0] U_addr,
   input  logic [17:0] D_addr,
   input  logic [15:0] V_wdata,
   input  logic [15:0] U_wdata,
   input  logic [15:0] D_wdata,

   output logic        V_gnt,
   output logic        U_gnt,
   output logic        D_gnt,
   output logic        V_rvalid,
   output logic        U_rvalid,
   output logic        D_rvalid,
   output logic [15:0] Rdata,

   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   input  logic [15:0] SRAM_read_data,

   input  logic        Freeze_req,
   output logic        Halted
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;
   typedef enum logic [1:0] {
      TAG_NONE = 2'b00,
      TAG_V    = 2'b01,
      TAG_U    = 2'b10,
      TAG_D    = 2'b11
   } tag_t;

   state_t      state;
   tag_t        tags [READ_LATENCY];
   logic        last_ud;               // 1: D was the last U/D grant
   tag_t        winner;
   logic [17:0] win_addr;
   logic [15:0] win_wdata;
   logic        win_we_n;
   logic        pipe_busy;
   logic        v_elig;
   logic        u_elig;
   logic        d_elig;

   assign Rdata = SRAM_read_data;

   // A requester being granted this cycle still holds req; skip it once.
   assign v_elig = V_req & ~V_gnt;
   assign u_elig = U_req & ~U_gnt;
   assign d_elig = D_req & ~D_gnt;

   always_comb begin
      // NOTE: default assignment first keeps this combinational (no latch).
      winner = TAG_NONE;
      if (state == S_RUN && !Freeze_req) begin
         if (v_elig)                 winner = TAG_V;
         else if (u_elig && d_elig)  winner = last_ud ? TAG_U : TAG_D;
         else if (u_elig)            winner = TAG_U;
         else if (d_elig)            winner = TAG_D;
      end
   end

   always_comb begin
      win_addr  = V_addr;
      win_wdata = V_wdata;
      win_we_n  = V_we_n;
      case (winner)
         TAG_U: begin
            win_addr  = U_addr;
            win_wdata = U_wdata;
            win_we_n  = U_we_n;
         end
         TAG_D: begin
            win_addr  = D_addr;
            win_wdata = D_wdata;
            win_we_n  = D_we_n;
         end
         default: ;
      endcase
   end

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < READ_LATENCY; i++)
         if (tags[i] != TAG_NONE) pipe_busy = 1'b1;
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state           <= S_RUN;
         V_gnt           <= 1'b0;
         U_gnt           <= 1'b0;
         D_gnt           <= 1'b0;
         V_rvalid        <= 1'b0;
         U_rvalid        <= 1'b0;
         D_rvalid        <= 1'b0;
         SRAM_we_n       <= 1'b1;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         last_ud         <= 1'b1;
         Halted          <= 1'b0;
         // NOTE: the owner-tag pipe is reset so reads in flight at reset never return.
         for (int i = 0; i < READ_LATENCY; i++)
            tags[i] <= TAG_NONE;
      end else begin
         V_gnt <= (winner == TAG_V);
         U_gnt <= (winner == TAG_U);
         D_gnt <= (winner == TAG_D);

         if (winner != TAG_NONE) begin
            SRAM_address    <= win_addr;
            SRAM_write_data <= win_wdata;
            SRAM_we_n       <= win_we_n;
         end else begin
            SRAM_we_n       <= 1'b1;
         end

         if (winner == TAG_U)      last_ud <= 1'b0;
         else if (winner == TAG_D) last_ud <= 1'b1;

         tags[0] <= (winner != TAG_NONE && win_we_n) ? winner : TAG_NONE;
         for (int i = 1; i < READ_LATENCY; i++)
            tags[i] <= tags[i-1];

         V_rvalid <= (tags[READ_LATENCY-1] == TAG_V);
         U_rvalid <= (tags[READ_LATENCY-1] == TAG_U);
         D_rvalid <= (tags[READ_LATENCY-1] == TAG_D);

         // Arbitration runs only in S_RUN, so leaving S_HALTED costs one idle edge.
         case (state)
            S_RUN: begin
               if (Freeze_req) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!pipe_busy) begin
                  state  <= S_HALTED;
                  Halted <= 1'b1;
               end
            end
            S_HALTED: begin
               if (!Freeze_req) begin
                  state  <= S_RUN;
                  Halted <= 1'b0;
               end
            end
            default: begin
               state  <= S_RUN;
               Halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_sram_access_arbiter;

   localparam int LAT = 3;

   logic        Clock;
   logic        Resetn;
   logic        req   [3];
   logic        we_n  [3];
   logic [17:0] addr  [3];
   logic [15:0] wdata [3];
   logic        V_gnt, U_gnt, D_gnt;
   logic        V_rvalid, U_rvalid, D_rvalid;
   logic [15:0] Rdata;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic [15:0] SRAM_read_data;
   logic        Freeze_req;
   logic        Halted;

   sram_access_arbiter #(.READ_LATENCY(LAT)) dut (
      .Clock           (Clock),
      .Resetn          (Resetn),
      .V_req           (req[0]),
      .U_req           (req[1]),
      .D_req           (req[2]),
      .V_we_n          (we_n[0]),
      .U_we_n          (we_n[1]),
      .D_we_n          (we_n[2]),
      .V_addr          (addr[0]),
      .U_addr          (addr[1]),
      .D_addr          (addr[2]),
      .V_wdata         (wdata[0]),
      .U_wdata         (wdata[1]),
      .D_wdata         (wdata[2]),
      .V_gnt           (V_gnt),
      .U_gnt           (U_gnt),
      .D_gnt           (D_gnt),
      .V_rvalid        (V_rvalid),
      .U_rvalid        (U_rvalid),
      .D_rvalid        (D_rvalid),
      .Rdata           (Rdata),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n),
      .SRAM_read_data  (SRAM_read_data),
      .Freeze_req      (Freeze_req),
      .Halted          (Halted)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: requesters indexed 0=V, 1=U, 2=D; outstanding reads
   // kept as a queue of (requester, cycle in which its data is due).
   typedef enum {RUNNING, DRAINING, STOPPED} mode_t;
   typedef struct {
      int who;
      int due;
   } rd_t;

   mode_t       m_mode;
   bit          m_u_first;
   bit          m_gnt    [3];
   bit          m_rvalid [3];
   logic [17:0] m_addr;
   logic [15:0] m_wdata;
   logic        m_we_n;
   bit          m_halted;
   rd_t         pending [$];
   int          cyc = 0;

   task automatic model_edge();
      int  winner;
      int  nxt;
      bit  u_ok;
      bit  d_ok;
      nxt = cyc + 1;
      if (!Resetn) begin
         m_mode    = RUNNING;
         m_u_first = 1'b1;
         m_addr    = '0;
         m_wdata   = '0;
         m_we_n    = 1'b1;
         m_halted  = 1'b0;
         pending.delete();
         for (int i = 0; i < 3; i++) begin
            m_gnt[i]    = 1'b0;
            m_rvalid[i] = 1'b0;
         end
      end else begin
         winner = -1;
         if (m_mode == RUNNING && !Freeze_req) begin
            u_ok = req[1] && !m_gnt[1];
            d_ok = req[2] && !m_gnt[2];
            if (req[0] && !m_gnt[0]) winner = 0;
            else if (u_ok && d_ok)   winner = m_u_first ? 1 : 2;
            else if (u_ok)           winner = 1;
            else if (d_ok)           winner = 2;
         end
         case (m_mode)
            RUNNING:  if (Freeze_req)          m_mode = DRAINING;
            DRAINING: if (pending.size() == 0) m_mode = STOPPED;
            STOPPED:  if (!Freeze_req)         m_mode = RUNNING;
            default:  m_mode = RUNNING;
         endcase
         for (int i = 0; i < 3; i++) m_gnt[i] = (i == winner);
         if (winner >= 0) begin
            m_addr  = addr[winner];
            m_wdata = wdata[winner];
            m_we_n  = we_n[winner];
            if (we_n[winner]) pending.push_back('{winner, nxt + LAT});
            if (winner == 1) m_u_first = 1'b0;
            if (winner == 2) m_u_first = 1'b1;
         end else begin
            m_we_n = 1'b1;
         end
         for (int i = 0; i < 3; i++) m_rvalid[i] = 1'b0;
         while (pending.size() > 0 && pending[0].due == nxt) begin
            m_rvalid[pending[0].who] = 1'b1;
            void'(pending.pop_front());
         end
         m_halted = (m_mode == STOPPED);
      end
      cyc = nxt;
   endtask

   task automatic compare_outputs();
      check("gnt",    32'({V_gnt, U_gnt, D_gnt}),          32'({m_gnt[0], m_gnt[1], m_gnt[2]}));
      check("rvalid", 32'({V_rvalid, U_rvalid, D_rvalid}), 32'({m_rvalid[0], m_rvalid[1], m_rvalid[2]}));
      check("we_n",   32'(SRAM_we_n),       32'(m_we_n));
      check("addr",   32'(SRAM_address),    32'(m_addr));
      check("wdata",  32'(SRAM_write_data), 32'(m_wdata));
      check("halted", 32'(Halted),          32'(m_halted));
      SRAM_read_data = 16'($urandom);
      #1;
      check("rdata",  32'(Rdata), 32'(SRAM_read_data));
   endtask

   // One clock: model consumes the inputs present at the edge, DUT is sampled 1ns after it.
   task automatic step();
      model_edge();
      @(posedge Clock);
      #1;
      compare_outputs();
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         req[i]   = 1'b0;
         we_n[i]  = 1'b1;
         addr[i]  = '0;
         wdata[i] = '0;
      end
      Freeze_req = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      Resetn = 1'b0;
      step();
      step();
      Resetn = 1'b1;
   endtask

   typedef struct {
      logic [2:0] req;      // {V,U,D}
      logic       freeze;
      logic [2:0] gnt;      // {V,U,D} expected in the following cycle
      logic       halted;
   } vec_t;

   vec_t tbl [18];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{3'b011, 1'b0, 3'b010, 1'b0};
      tbl[1]  = '{3'b011, 1'b0, 3'b001, 1'b0};
      tbl[2]  = '{3'b011, 1'b0, 3'b010, 1'b0};
      tbl[3]  = '{3'b011, 1'b0, 3'b001, 1'b0};
      tbl[4]  = '{3'b111, 1'b0, 3'b100, 1'b0};
      tbl[5]  = '{3'b111, 1'b0, 3'b010, 1'b0};
      tbl[6]  = '{3'b111, 1'b0, 3'b100, 1'b0};
      tbl[7]  = '{3'b111, 1'b0, 3'b001, 1'b0};
      tbl[8]  = '{3'b000, 1'b0, 3'b000, 1'b0};
      tbl[9]  = '{3'b010, 1'b0, 3'b010, 1'b0};
      tbl[10] = '{3'b010, 1'b0, 3'b000, 1'b0};
      tbl[11] = '{3'b010, 1'b0, 3'b010, 1'b0};
      tbl[12] = '{3'b011, 1'b0, 3'b001, 1'b0};
      tbl[13] = '{3'b011, 1'b0, 3'b010, 1'b0};
      tbl[14] = '{3'b100, 1'b1, 3'b000, 1'b0};
      tbl[15] = '{3'b100, 1'b0, 3'b000, 1'b1};
      tbl[16] = '{3'b100, 1'b0, 3'b000, 1'b0};
      tbl[17] = '{3'b100, 1'b0, 3'b100, 1'b0};

      SRAM_read_data = '0;
      do_reset();
      check("reset_gnt",  32'({V_gnt, U_gnt, D_gnt}), 32'(0));
      check("reset_we_n", 32'(SRAM_we_n), 32'(1));
      check("reset_addr", 32'(SRAM_address), 32'(0));

      // Directed table: all writes, so grant ordering and freeze are isolated.
      for (int i = 0; i < 3; i++) begin
         we_n[i]  = 1'b0;
         addr[i]  = 18'(18'h10000 + i);
         wdata[i] = 16'(16'hA000 + i);
      end
      for (int i = 0; i < 18; i++) begin
         req[0]     = tbl[i].req[2];
         req[1]     = tbl[i].req[1];
         req[2]     = tbl[i].req[0];
         Freeze_req = tbl[i].freeze;
         step();
         check($sformatf("tbl%0d_gnt", i), 32'({V_gnt, U_gnt, D_gnt}), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d_halted", i), 32'(Halted), 32'(tbl[i].halted));
      end

      // V has priority over U; read returns LAT cycles after its grant.
      do_reset();
      req[0] = 1'b1; addr[0] = 18'h00100;
      req[1] = 1'b1; addr[1] = 18'h00222;
      step();
      check("a_vgnt", 32'(V_gnt), 32'(1));
      check("a_addr", 32'(SRAM_address), 32'(18'h00100));
      check("a_we_n", 32'(SRAM_we_n), 32'(1));
      req[0] = 1'b0;
      step();
      check("a_ugnt", 32'(U_gnt), 32'(1));
      req[1] = 1'b0;
      for (int k = 3; k <= 2 + LAT; k++) begin
         step();
         if (k == 1 + LAT) check("a_vrvalid", 32'(V_rvalid), 32'(1));
         if (k == 2 + LAT) check("a_urvalid", 32'(U_rvalid), 32'(1));
      end

      // D write at the top address: one-cycle write strobe, no read return.
      do_reset();
      req[2] = 1'b1; we_n[2] = 1'b0; addr[2] = 18'h3FFFF; wdata[2] = 16'hBEEF;
      step();
      check("b_dgnt",  32'(D_gnt), 32'(1));
      check("b_we_n",  32'(SRAM_we_n), 32'(0));
      check("b_addr",  32'(SRAM_address), 32'(18'h3FFFF));
      check("b_wdata", 32'(SRAM_write_data), 32'(16'hBEEF));
      req[2] = 1'b0;
      step();
      check("b_we_n_after", 32'(SRAM_we_n), 32'(1));
      check("b_addr_hold",  32'(SRAM_address), 32'(18'h3FFFF));
      for (int k = 0; k <= LAT; k++) begin
         step();
         check("b_no_rvalid", 32'(D_rvalid), 32'(0));
      end

      // Reads V,U,V back to back give back-to-back rvalids in grant order.
      do_reset();
      req[0] = 1'b1; addr[0] = 18'h00AA0;
      req[1] = 1'b1; addr[1] = 18'h00BB0;
      step();
      step();
      step();
      check("c_v2gnt", 32'(V_gnt), 32'(1));
      req[0] = 1'b0;
      req[1] = 1'b0;
      for (int k = 4; k <= 6; k++) begin
         step();
         check("c_rvalid", 32'({V_rvalid, U_rvalid, D_rvalid}), 32'((k == 5) ? 3'b010 : 3'b100));
      end

      // Freeze with two reads outstanding; D request waits through the freeze.
      do_reset();
      req[0] = 1'b1;
      req[1] = 1'b1;
      step();
      req[0] = 1'b0;
      step();
      req[1] = 1'b0;
      Freeze_req = 1'b1;
      req[2] = 1'b1; addr[2] = 18'h01234;
      for (int k = 3; k <= 8; k++) begin
         step();
         check("d_no_gnt", 32'({V_gnt, U_gnt, D_gnt}), 32'(0));
         check("d_halted", 32'(Halted), 32'(k >= 3 + LAT));
      end
      Freeze_req = 1'b0;
      step();
      check("d_resume_halted", 32'(Halted), 32'(0));
      step();
      check("d_resume_gnt", 32'(D_gnt), 32'(1));
      req[2] = 1'b0;
      for (int k = 0; k <= LAT; k++) step();

      // Reset one cycle after a read grant discards the read.
      do_reset();
      req[0] = 1'b1; addr[0] = 18'h15555; wdata[0] = 16'h1234;
      step();
      req[0] = 1'b0;
      Resetn = 1'b0;
      step();
      check("e_gnt",    32'({V_gnt, U_gnt, D_gnt}), 32'(0));
      check("e_we_n",   32'(SRAM_we_n), 32'(1));
      check("e_addr",   32'(SRAM_address), 32'(0));
      check("e_wdata",  32'(SRAM_write_data), 32'(0));
      check("e_halted", 32'(Halted), 32'(0));
      Resetn = 1'b1;
      for (int k = 0; k <= LAT + 1; k++) begin
         step();
         check("e_no_rvalid", 32'({V_rvalid, U_rvalid, D_rvalid}), 32'(0));
      end

      // Randomized traffic against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 3; i++) begin
            req[i]   = ($urandom_range(0, 99) < 55);
            we_n[i]  = 1'($urandom);
            addr[i]  = 18'($urandom);
            wdata[i] = 16'($urandom);
         end
         if ($urandom_range(0, 99) < 3) Freeze_req = ~Freeze_req;
         Resetn = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
